// File: rtl/problema1_processor_ocimem_ctrl.sv
// OCI debug RAM controller: executes sysclk-domain JTAG debug commands against a DEPTH x 32 RAM
// and shares that RAM with an Avalon-MM slave port; a JTAG command always wins over the CPU.
module problema1_processor_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              av_chipselect,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [ADDR_W-1:0] av_address,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, JRD, AVRD} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] monAReg_q, monAReg_d;
  logic [31:0]       monDReg_q, monDReg_d;
  logic [31:0]       avRdData_q, avRdData_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ramRd_q;
  logic              rdOob_q;
  logic [31:0]       ramData;

  logic [ADDR_W-1:0] rdAddr, wrAddr, jAddr;
  logic [31:0]       wrData;
  logic [3:0]        wrBe;
  logic              wrEn;
  logic              anyPulse, avSel, avWait;
  logic              unusedJdo;

  function automatic logic isOob(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= DEPTH_C;
  endfunction

  assign jAddr     = ADDR_W'(jdo[33:26]);
  assign anyPulse  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign avSel     = av_chipselect & (state_q == IDLE) & ~anyPulse;
  assign ramData   = rdOob_q ? '0 : ramRd_q;
  assign unusedJdo = ^{jdo[37:36], jdo[2:0]};

  // The RAM read is launched in the IDLE cycle that accepts a command, so the data is
  // registered on the following edge and lands in MonDReg / av_readdata one edge later.
  always_comb begin
    state_d    = state_q;
    monAReg_d  = monAReg_q;
    monDReg_d  = monDReg_q;
    avRdData_d = avRdData_q;
    ready_d    = ready_q;
    error_d    = error_q;
    rdAddr     = monAReg_q;
    wrEn       = 1'b0;
    wrAddr     = monAReg_q;
    wrData     = jdo[34:3];
    wrBe       = 4'hF;

    unique case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          monAReg_d = jAddr;
          ready_d   = 1'b0;
          error_d   = isOob(jAddr) | take_action_ocimem_b | take_no_action_ocimem_a;
          rdAddr    = jAddr;
          if (jdo[35]) state_d = JRD;
        end else if (take_action_ocimem_b) begin
          wrEn      = ~isOob(monAReg_q);
          monAReg_d = monAReg_q + ADDR_W'(1);
          ready_d   = 1'b1;
          if (isOob(monAReg_q) || take_no_action_ocimem_a) error_d = 1'b1;
        end else if (take_no_action_ocimem_a) begin
          ready_d = 1'b0;
          state_d = JRD;
        end else if (avSel && av_read) begin
          rdAddr  = av_address;
          state_d = AVRD;
        end else if (avSel && av_write) begin
          wrEn   = ~isOob(av_address);
          wrAddr = av_address;
          wrData = av_writedata;
          wrBe   = av_byteenable;
        end
      end
      JRD: begin
        monDReg_d = ramData;
        ready_d   = 1'b1;
        monAReg_d = monAReg_q + ADDR_W'(1);
        state_d   = IDLE;
        if (anyPulse) error_d = 1'b1;
      end
      AVRD: begin
        avRdData_d = ramData;
        state_d    = IDLE;
        if (anyPulse) error_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    avWait = 1'b1;
    unique case (state_q)
      IDLE:    avWait = anyPulse | av_read;
      JRD:     avWait = 1'b1;
      AVRD:    avWait = ~av_read;
      default: avWait = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      monAReg_q  <= '0;
      monDReg_q  <= '0;
      avRdData_q <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      monAReg_q  <= monAReg_d;
      monDReg_q  <= monDReg_d;
      avRdData_q <= avRdData_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
    end
  end

  // RAM contents survive reset, but a write sampled together with reset must not land.
  always_ff @(posedge clk) begin
    if (wrEn && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wrBe[b]) mem[wrAddr][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
    ramRd_q <= mem[rdAddr];
    rdOob_q <= isOob(rdAddr);
  end

  assign av_readdata    = (state_q == AVRD) ? ramData : avRdData_q;
  assign av_waitrequest = av_chipselect & avWait;
  assign MonDReg        = monDReg_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;

endmodule

// File: tb/tb_problema1_processor_ocimem_ctrl.sv
// Self-checking bench for the OCI RAM controller; expected read data flows through
// scoreboard queues filled from a bench-side RAM model when each read is issued.
module tb_problema1_processor_ocimem_ctrl;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [37:0]       jdo;
  logic              takeA, takeB, takeNa;
  logic              av_chipselect, av_read, av_write;
  logic [ADDR_W-1:0] av_address;
  logic [31:0]       av_writedata;
  logic [3:0]        av_byteenable;
  logic [31:0]       av_readdata;
  logic              av_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [256];
  logic [31:0] jtagQ [$];
  logic [31:0] avQ [$];

  problema1_processor_ocimem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(takeA), .take_action_ocimem_b(takeB),
    .take_no_action_ocimem_a(takeNa),
    .av_chipselect(av_chipselect), .av_read(av_read), .av_write(av_write),
    .av_address(av_address), .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle JTAG pulse(s); the ocimem_a fields take precedence in jdo when a is set.
  task automatic pulse(input bit a, input bit b, input bit na,
                       input logic [7:0] addr, input bit rd, input logic [31:0] data);
    jdo = '0;
    if (a) begin
      jdo[35]    = rd;
      jdo[33:26] = addr;
    end else begin
      jdo[34:3] = data;
    end
    takeA = a; takeB = b; takeNa = na;
    tick();
    takeA = 1'b0; takeB = 1'b0; takeNa = 1'b0;
  endtask

  task automatic waitReady(output int edges);
    edges = 1;
    while (monitor_ready !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    if (monitor_ready !== 1'b1) edges = -1;
  endtask

  task automatic avRead(input logic [7:0] addr, output int stalls);
    av_chipselect = 1'b1; av_read = 1'b1; av_write = 1'b0; av_address = addr;
    stalls = 0;
    #1;
    while (av_waitrequest !== 1'b0 && stalls < 10) begin
      stalls++;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic avRelease();
    @(posedge clk);
    #1;
    av_chipselect = 1'b0; av_read = 1'b0; av_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (monitor_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", monitor_ready); end
    checks++; if (monitor_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_error: got %b expected 0", monitor_error); end
    checks++; if (MonDReg !== 32'h0) begin failures++; $display("[TB] FAIL reset_mondreg: got %h expected 0", MonDReg); end
    checks++; if (av_readdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_readdata: got %h expected 0", av_readdata); end
    checks++; if (av_waitrequest !== 1'b0) begin failures++; $display("[TB] FAIL reset_wait: got %b expected 0", av_waitrequest); end
  endtask

  task automatic test_jtag_write();
    pulse(1, 0, 0, 8'd0, 0, 32'h0);
    checks++; if (monitor_ready !== 1'b0) begin failures++; $display("[TB] FAIL loadA_ready: got %b expected 0", monitor_ready); end
    pulse(0, 1, 0, 8'd0, 0, 32'hDEAD_BEEF);
    model[0] = 32'hDEAD_BEEF;
    checks++; if (monitor_ready !== 1'b1) begin failures++; $display("[TB] FAIL writeB0_ready: got %b expected 1", monitor_ready); end
    pulse(1, 0, 0, 8'd5, 0, 32'h0);
    checks++; if (monitor_ready !== 1'b0) begin failures++; $display("[TB] FAIL loadA5_ready: got %b expected 0", monitor_ready); end
    pulse(0, 1, 0, 8'd0, 0, 32'hA5A5_0001);
    model[5] = 32'hA5A5_0001;
    checks++; if (monitor_ready !== 1'b1) begin failures++; $display("[TB] FAIL writeB5_ready: got %b expected 1", monitor_ready); end
    pulse(0, 1, 0, 8'd0, 0, 32'h1234_5678);
    model[6] = 32'h1234_5678;
    checks++; if (monitor_error !== 1'b0) begin failures++; $display("[TB] FAIL write_error: got %b expected 0", monitor_error); end
  endtask

  task automatic test_jtag_read();
    int n;
    logic [31:0] exp;
    jtagQ.push_back(model[5]);
    pulse(1, 0, 0, 8'd5, 1, 32'h0);
    waitReady(n);
    checks++; if (n !== 2) begin failures++; $display("[TB] FAIL readA_latency: got %0d expected 2", n); end
    exp = jtagQ.pop_front();
    checks++; if (MonDReg !== exp) begin failures++; $display("[TB] FAIL readA_data: got %h expected %h", MonDReg, exp); end
    checks++; if (monitor_error !== 1'b0) begin failures++; $display("[TB] FAIL readA_error: got %b expected 0", monitor_error); end
    jtagQ.push_back(model[6]);
    pulse(0, 0, 1, 8'd0, 0, 32'h0);
    waitReady(n);
    checks++; if (n !== 2) begin failures++; $display("[TB] FAIL readNa_latency: got %0d expected 2", n); end
    exp = jtagQ.pop_front();
    checks++; if (MonDReg !== exp) begin failures++; $display("[TB] FAIL readNa_postinc: got %h expected %h", MonDReg, exp); end
  endtask

  task automatic test_out_of_range();
    int n;
    logic [31:0] exp;
    pulse(1, 0, 0, 8'd255, 0, 32'h0);
    checks++; if (monitor_error !== 1'b1) begin failures++; $display("[TB] FAIL oobLoad_error: got %b expected 1", monitor_error); end
    pulse(0, 1, 0, 8'd0, 0, 32'h1111_2222);
    checks++; if (monitor_ready !== 1'b1) begin failures++; $display("[TB] FAIL oobWrite_ready: got %b expected 1", monitor_ready); end
    checks++; if (monitor_error !== 1'b1) begin failures++; $display("[TB] FAIL oobWrite_error: got %b expected 1", monitor_error); end
    pulse(1, 0, 0, 8'd255, 0, 32'h0);
    jtagQ.push_back(32'h0);
    pulse(0, 0, 1, 8'd0, 0, 32'h0);
    waitReady(n);
    exp = jtagQ.pop_front();
    checks++; if (MonDReg !== exp) begin failures++; $display("[TB] FAIL oobRead_data: got %h expected %h", MonDReg, exp); end
    jtagQ.push_back(model[0]);
    pulse(0, 0, 1, 8'd0, 0, 32'h0);
    waitReady(n);
    exp = jtagQ.pop_front();
    checks++; if (MonDReg !== exp) begin failures++; $display("[TB] FAIL wrap_data: got %h expected %h", MonDReg, exp); end
    pulse(1, 0, 0, 8'd5, 0, 32'h0);
    checks++; if (monitor_error !== 1'b0) begin failures++; $display("[TB] FAIL errorClear: got %b expected 0", monitor_error); end
  endtask

  task automatic test_priority();
    int n;
    logic [31:0] exp;
    pulse(1, 1, 1, 8'd6, 0, 32'h0);
    checks++; if (monitor_error !== 1'b1) begin failures++; $display("[TB] FAIL prioABN_error: got %b expected 1", monitor_error); end
    jtagQ.push_back(model[6]);
    pulse(0, 0, 1, 8'd0, 0, 32'h0);
    waitReady(n);
    exp = jtagQ.pop_front();
    checks++; if (MonDReg !== exp) begin failures++; $display("[TB] FAIL prioA_wins: got %h expected %h", MonDReg, exp); end
    pulse(0, 1, 1, 8'd0, 0, 32'hCAFE_0007);
    model[7] = 32'hCAFE_0007;
    checks++; if (monitor_ready !== 1'b1) begin failures++; $display("[TB] FAIL prioB_ready: got %b expected 1", monitor_ready); end
    jtagQ.push_back(model[7]);
    pulse(1, 0, 0, 8'd7, 1, 32'h0);
    waitReady(n);
    exp = jtagQ.pop_front();
    checks++; if (MonDReg !== exp) begin failures++; $display("[TB] FAIL prioB_data: got %h expected %h", MonDReg, exp); end
    checks++; if (monitor_error !== 1'b0) begin failures++; $display("[TB] FAIL prioClear_error: got %b expected 0", monitor_error); end
  endtask

  task automatic test_dropped();
    logic [31:0] exp;
    jtagQ.push_back(model[6]);
    pulse(1, 0, 0, 8'd6, 1, 32'h0);
    pulse(0, 0, 1, 8'd0, 0, 32'h0);
    exp = jtagQ.pop_front();
    checks++; if (monitor_ready !== 1'b1) begin failures++; $display("[TB] FAIL drop_ready: got %b expected 1", monitor_ready); end
    checks++; if (MonDReg !== exp) begin failures++; $display("[TB] FAIL drop_data: got %h expected %h", MonDReg, exp); end
    checks++; if (monitor_error !== 1'b1) begin failures++; $display("[TB] FAIL drop_error: got %b expected 1", monitor_error); end
    tick();
    checks++; if (monitor_ready !== 1'b1) begin failures++; $display("[TB] FAIL drop_notExecuted: got %b expected 1", monitor_ready); end
  endtask

  task automatic test_avalon_collision();
    int stalls;
    logic [31:0] exp;
    jtagQ.push_back(model[7]);
    avQ.push_back(model[5]);
    jdo = '0; jdo[35] = 1'b1; jdo[33:26] = 8'd7; takeA = 1'b1;
    av_chipselect = 1'b1; av_read = 1'b1; av_write = 1'b0; av_address = 8'd5;
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (av_waitrequest === 1'b0) break;
      stalls++;
      @(posedge clk);
      #1;
      takeA = 1'b0;
    end
    checks++; if (stalls !== 3) begin failures++; $display("[TB] FAIL collide_stalls: got %0d expected 3", stalls); end
    exp = avQ.pop_front();
    checks++; if (av_readdata !== exp) begin failures++; $display("[TB] FAIL collide_avdata: got %h expected %h", av_readdata, exp); end
    exp = jtagQ.pop_front();
    checks++; if (MonDReg !== exp) begin failures++; $display("[TB] FAIL collide_jtagdata: got %h expected %h", MonDReg, exp); end
    avRelease();
    tick();
    checks++; if (av_readdata !== model[5]) begin failures++; $display("[TB] FAIL readdata_hold: got %h expected %h", av_readdata, model[5]); end
  endtask

  task automatic test_avalon_write();
    int stalls, n;
    logic [31:0] exp;
    av_chipselect = 1'b1; av_write = 1'b1; av_read = 1'b0; av_address = 8'd5;
    av_writedata = 32'h0000_3C00; av_byteenable = 4'b0010;
    #1;
    checks++; if (av_waitrequest !== 1'b0) begin failures++; $display("[TB] FAIL avWrite_wait: got %b expected 0", av_waitrequest); end
    avRelease();
    model[5][15:8] = 8'h3C;
    avQ.push_back(model[5]);
    avRead(8'd5, stalls);
    checks++; if (stalls !== 1) begin failures++; $display("[TB] FAIL avRead_stalls: got %0d expected 1", stalls); end
    exp = avQ.pop_front();
    checks++; if (av_readdata !== exp) begin failures++; $display("[TB] FAIL avByteWrite: got %h expected %h", av_readdata, exp); end
    avRelease();
    avQ.push_back(32'h0);
    avRead(8'd210, stalls);
    exp = avQ.pop_front();
    checks++; if (av_readdata !== exp) begin failures++; $display("[TB] FAIL avOob_data: got %h expected %h", av_readdata, exp); end
    avRelease();
    jtagQ.push_back(model[5]);
    pulse(1, 0, 0, 8'd5, 1, 32'h0);
    waitReady(n);
    exp = jtagQ.pop_front();
    checks++; if (MonDReg !== exp) begin failures++; $display("[TB] FAIL avWrite_jtagView: got %h expected %h", MonDReg, exp); end
  endtask

  task automatic test_reset_mid();
    int stalls, n;
    logic [31:0] exp;
    pulse(1, 0, 0, 8'd5, 1, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (monitor_ready !== 1'b0) begin failures++; $display("[TB] FAIL midReset_ready: got %b expected 0", monitor_ready); end
    checks++; if (MonDReg !== 32'h0) begin failures++; $display("[TB] FAIL midReset_mondreg: got %h expected 0", MonDReg); end
    tick();
    checks++; if (monitor_ready !== 1'b0) begin failures++; $display("[TB] FAIL midReset_aborted: got %b expected 0", monitor_ready); end
    avQ.push_back(model[5]);
    avRead(8'd5, stalls);
    exp = avQ.pop_front();
    checks++; if (av_readdata !== exp) begin failures++; $display("[TB] FAIL midReset_ram: got %h expected %h", av_readdata, exp); end
    avRelease();
    reset = 1'b1;
    jdo = '0; jdo[34:3] = 32'h0BAD_0BAD; takeB = 1'b1;
    tick();
    takeB = 1'b0; reset = 1'b0;
    jtagQ.push_back(model[0]);
    pulse(0, 0, 1, 8'd0, 0, 32'h0);
    waitReady(n);
    exp = jtagQ.pop_front();
    checks++; if (MonDReg !== exp) begin failures++; $display("[TB] FAIL resetWrite_blocked: got %h expected %h", MonDReg, exp); end
  endtask

  task automatic test_back_to_back();
    int n, stalls;
    logic [31:0] exp, data;
    pulse(1, 0, 0, 8'd20, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      data = $urandom;
      pulse(0, 1, 0, 8'd0, 0, data);
      model[20 + i] = data;
      checks++; if (monitor_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2bWrite_ready%0d: got %b expected 1", i, monitor_ready); end
    end
    jtagQ.push_back(model[20]);
    pulse(1, 0, 0, 8'd20, 1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        jtagQ.push_back(model[20 + i]);
        pulse(0, 0, 1, 8'd0, 0, 32'h0);
      end
      waitReady(n);
      exp = jtagQ.pop_front();
      checks++; if (MonDReg !== exp) begin failures++; $display("[TB] FAIL b2bJtagRead%0d: got %h expected %h", i, MonDReg, exp); end
    end
    for (int i = 0; i < 4; i++) begin
      avQ.push_back(model[20 + i]);
      avRead(8'(20 + i), stalls);
      exp = avQ.pop_front();
      checks++; if (av_readdata !== exp || stalls !== 1) begin failures++; $display("[TB] FAIL b2bAvRead%0d: got %h/%0d expected %h/1", i, av_readdata, stalls, exp); end
      avRelease();
    end
  endtask

  initial begin
    reset = 1'b1; jdo = '0; takeA = 1'b0; takeB = 1'b0; takeNa = 1'b0;
    av_chipselect = 1'b0; av_read = 1'b0; av_write = 1'b0;
    av_address = '0; av_writedata = '0; av_byteenable = '0;
    for (int i = 0; i < 256; i++) model[i] = '0;
    tick();
    test_reset();
    test_jtag_write();
    test_jtag_read();
    test_out_of_range();
    test_priority();
    test_dropped();
    test_avalon_collision();
    test_avalon_write();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
